bist_counter_ctrl: RTL and testbench

Built-in self-test sequencer for the fast 6:3 counter datapath and the three-bit stacker stages it is built from. It drives every input pattern into the counter under test and computes the golden population count internally. It compares the counter output against that golden value, accounting for pipeline latency, and reports the result through pass/fail and error status. It sits between the test-mode control logic and the counter datapath.

---
 rtl/bist_counter_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_bist_counter_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bist_counter_ctrl.sv
`default_nettype none
// ===========================================================================
// bist_counter_ctrl : exhaustive BIST sequencer/checker for a popcount datapath
// Rev 1.0
// ===========================================================================
module bist_counter_ctrl #(
    parameter int WIDTH = 6,
    parameter int LAT   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic                             abort_i,
    output logic [WIDTH-1:0]                 dut_in_o,
    input  logic [$clog2(WIDTH+1)-1:0]       dut_out_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             pass_o,
    output logic [7:0]                       err_count_o,
    output logic [WIDTH-1:0]                 first_fail_o
);

    localparam int OUT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pat_q;
    logic [2:0]       drain_q;
    logic [7:0]       err_q, err_d;
    logic [WIDTH-1:0] ff_q, ff_d;
    logic             flag_q, flag_d;
    logic             busy_q, done_q, pass_q;

    logic             launch;
    logic             vld_in;
    logic [OUT_W-1:0] gold_in;
    logic [OUT_W-1:0] gold_dly;
    logic             vld_dly;
    logic [WIDTH-1:0] pat_dly;
    logic             mismatch;

    function automatic logic [OUT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [OUT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + OUT_W'(v[i]);
        end
        return c;
    endfunction

    // The pattern register is zero outside APPLY, so it drives the DUT directly.
    assign dut_in_o = pat_q;
    assign gold_in  = popcount(pat_q);
    assign launch   = ((state_q == IDLE) || (state_q == DONE)) && start_i;
    assign vld_in   = (state_q == APPLY) && !abort_i;

    generate
        if (LAT == 0) begin : g_direct
            assign gold_dly = gold_in;
            assign vld_dly  = (state_q == APPLY);
            assign pat_dly  = pat_q;
        end else begin : g_pipe
            logic [OUT_W-1:0] gold_q [LAT];
            logic             vld_q  [LAT];
            logic [WIDTH-1:0] src_q  [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        gold_q[i] <= '0;
                        vld_q[i]  <= 1'b0;
                        src_q[i]  <= '0;
                    end
                end else if (launch) begin
                    for (int i = 0; i < LAT; i++) begin
                        gold_q[i] <= '0;
                        vld_q[i]  <= 1'b0;
                        src_q[i]  <= '0;
                    end
                end else begin
                    gold_q[0] <= gold_in;
                    vld_q[0]  <= vld_in;
                    src_q[0]  <= pat_q;
                    for (int i = 1; i < LAT; i++) begin
                        gold_q[i] <= gold_q[i-1];
                        vld_q[i]  <= vld_q[i-1];
                        src_q[i]  <= src_q[i-1];
                    end
                end
            end

            assign gold_dly = gold_q[LAT-1];
            assign vld_dly  = vld_q[LAT-1];
            assign pat_dly  = src_q[LAT-1];
        end
    endgenerate

    // Results only move while a run is live, so they freeze on abort and in DONE.
    always_comb begin
        mismatch = vld_dly && (dut_out_i != gold_dly) &&
                   ((state_q == APPLY) || (state_q == DRAIN));
        err_d  = err_q;
        ff_d   = ff_q;
        flag_d = flag_q;
        if (mismatch) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (!flag_q) begin
                ff_d   = pat_dly;
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            drain_q <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q <= APPLY;
                        pat_q   <= '0;
                        drain_q <= '0;
                        err_q   <= '0;
                        ff_q    <= '0;
                        flag_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        pat_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        err_q  <= err_d;
                        ff_q   <= ff_d;
                        flag_q <= flag_d;
                        pat_q  <= pat_q + WIDTH'(1);
                        if (pat_q == {WIDTH{1'b1}}) begin
                            if (LAT == 0) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= (err_d == 8'd0);
                            end else begin
                                state_q <= DRAIN;
                                drain_q <= '0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        pat_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        err_q  <= err_d;
                        ff_q   <= ff_d;
                        flag_q <= flag_d;
                        if (drain_q == 3'(LAT - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 8'd0);
                        end else begin
                            drain_q <= drain_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_count_o  = err_q;
    assign first_fail_o = ff_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_counter_ctrl.sv
`default_nettype none
// ===========================================================================
// tb_bist_counter_ctrl : directed bench for bist_counter_ctrl (three configs)
// Rev 1.0
// ===========================================================================
module tb_bist_counter_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   sel = 0;
    int   mode_a = 0;
    int   mode_b = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: WIDTH=6 LAT=0
    logic [5:0] dut_in_a;  logic [2:0] dut_out_a;
    logic busy_a, done_a, pass_a;  logic [7:0] err_a;  logic [5:0] ff_a;
    // B: WIDTH=6 LAT=2
    logic [5:0] dut_in_b;  logic [2:0] dut_out_b;
    logic busy_b, done_b, pass_b;  logic [7:0] err_b;  logic [5:0] ff_b;
    // C: WIDTH=9 LAT=0
    logic [8:0] dut_in_c;  logic [3:0] dut_out_c;
    logic busy_c, done_c, pass_c;  logic [7:0] err_c;  logic [8:0] ff_c;

    logic [2:0] s1_b, s2_b;
    logic       done_s;

    function automatic int pc(input logic [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    assign dut_out_a = (mode_a == 1) ? (3'(pc(32'(dut_in_a))) & 3'b110) : 3'(pc(32'(dut_in_a)));
    always @(posedge clk) begin
        s1_b <= 3'(pc(32'(dut_in_b)));
        s2_b <= s1_b;
    end
    assign dut_out_b = (mode_b == 1) ? s1_b : s2_b;
    assign dut_out_c = ~4'(pc(32'(dut_in_c)));
    assign done_s = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

    bist_counter_ctrl #(.WIDTH(6), .LAT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start && sel == 0), .abort_i(abort && sel == 0),
        .dut_in_o(dut_in_a), .dut_out_i(dut_out_a), .busy_o(busy_a), .done_o(done_a),
        .pass_o(pass_a), .err_count_o(err_a), .first_fail_o(ff_a));

    bist_counter_ctrl #(.WIDTH(6), .LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .start_i(start && sel == 1), .abort_i(abort && sel == 1),
        .dut_in_o(dut_in_b), .dut_out_i(dut_out_b), .busy_o(busy_b), .done_o(done_b),
        .pass_o(pass_b), .err_count_o(err_b), .first_fail_o(ff_b));

    bist_counter_ctrl #(.WIDTH(9), .LAT(0)) u_w9 (
        .clk(clk), .rst_n(rst_n), .start_i(start && sel == 2), .abort_i(abort && sel == 2),
        .dut_in_o(dut_in_c), .dut_out_i(dut_out_c), .busy_o(busy_c), .done_o(done_c),
        .pass_o(pass_c), .err_count_o(err_c), .first_fail_o(ff_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulses start, then waits for done; dc is the cycle in which done is first seen.
    task automatic run(input int s, input int pulse_at, output int dc, output int bad);
        int  c0;
        bit  found;
        sel   = s;
        bad   = 0;
        dc    = -1;
        found = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; c0 = cyc;
        for (int n = 0; n < 1100 && !found; n++) begin
            int k;
            k = cyc - c0;
            if (s == 0 && int'(dut_in_a) != ((k <= 63) ? k : 0)) bad++;
            if (done_s) begin
                found = 1;
                dc    = k + 1;
            end else begin
                start = (k == pulse_at);
                @(negedge clk);
            end
        end
        start = 0;
    endtask

    task automatic wait_pattern(input int p);
        int n = 0;
        while (int'(dut_in_a) != p && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_pattern", 32'(dut_in_a), 32'(p));
    endtask

    initial begin
        int dc, bad;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_pass", 32'(pass_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_ff", 32'(ff_a), 0);
        check("rst_dut_in", 32'(dut_in_a), 0);
        rst_n = 1;

        // fault-free, defaults
        mode_a = 0;
        run(0, -1, dc, bad);
        check("ok_done_cycle", 32'(dc), 65);
        check("ok_pass", 32'(pass_a), 1);
        check("ok_err", 32'(err_a), 0);
        check("ok_ff", 32'(ff_a), 0);
        check("ok_dut_in_seq", 32'(bad), 0);
        check("ok_busy_done", 32'(busy_a), 0);
        repeat (3) @(negedge clk);
        check("ok_hold_done", 32'(done_a), 1);
        check("ok_hold_dut_in", 32'(dut_in_a), 0);

        // stuck-at-0 on output bit 0
        mode_a = 1;
        run(0, -1, dc, bad);
        check("sa0_done_cycle", 32'(dc), 65);
        check("sa0_err", 32'(err_a), 32);
        check("sa0_ff", 32'(ff_a), 1);
        check("sa0_pass", 32'(pass_a), 0);
        repeat (4) @(negedge clk);
        check("sa0_hold_err", 32'(err_a), 32);

        // two-stage pipelined counter
        mode_b = 0;
        run(1, -1, dc, bad);
        check("lat2_done_cycle", 32'(dc), 67);
        check("lat2_pass", 32'(pass_b), 1);
        check("lat2_err", 32'(err_b), 0);
        mode_b = 1;
        run(1, -1, dc, bad);
        check("lat1model_pass", 32'(pass_b), 0);
        check("lat1model_err_nonzero", 32'(err_b != 8'd0), 1);

        // saturation with WIDTH=9, inverted output
        run(2, -1, dc, bad);
        check("sat_done_cycle", 32'(dc), 513);
        check("sat_err", 32'(err_c), 255);
        check("sat_ff", 32'(ff_c), 0);
        check("sat_pass", 32'(pass_c), 0);

        // abort at pattern 20, then clean rerun with a stray start in APPLY
        mode_a = 0;
        sel = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        wait_pattern(20);
        abort = 1;
        @(negedge clk); abort = 0;
        check("abort_busy", 32'(busy_a), 0);
        check("abort_done", 32'(done_a), 0);
        check("abort_pass", 32'(pass_a), 0);
        check("abort_dut_in", 32'(dut_in_a), 0);
        repeat (2) @(negedge clk);
        check("abort_idle_busy", 32'(busy_a), 0);
        run(0, 10, dc, bad);
        check("rerun_done_cycle", 32'(dc), 65);
        check("rerun_pass", 32'(pass_a), 1);
        check("rerun_dut_in_seq", 32'(bad), 0);

        // reset mid-run at pattern 40
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        wait_pattern(40);
        rst_n = 0;
        #1;
        check("mrst_busy", 32'(busy_a), 0);
        check("mrst_dut_in", 32'(dut_in_a), 0);
        check("mrst_done", 32'(done_a), 0);
        check("mrst_err", 32'(err_a), 0);
        @(negedge clk); rst_n = 1;
        run(0, -1, dc, bad);
        check("mrst_done_cycle", 32'(dc), 65);
        check("mrst_pass", 32'(pass_a), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
